// File: rtl/fetch_stage.sv
// Purpose : instruction fetch stage; drives the imem request, owns the PC and the IF/ID register.
// Latency : rdata accepted at a rising edge is on if_instr right after that edge (1 instr/cycle at zero wait).
// Backpres: freez holds the IF/ID register (a returning word is parked in HOLD); imem_addr is stable until ack.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   freez              hazard stall; keeps if_pc/if_instr/if_valid unchanged
//   branch_taken/addr  redirect request from EXE (highest priority after rst)
//   imem_req/addr      instruction memory request; addr == pc at all times
//   imem_ack/rdata     memory response, only honoured in REQ/KILL
//   if_pc/instr/valid  IF/ID register (if_pc is PC+4 of the held instruction)
//   stall_cnt          saturating freeze-cycle counter, present only when
//                      FETCH_STALL_CNT_EN is defined (otherwise tied to zero)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freez,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic [15:0] stall_cnt
);

  // REQ : request outstanding at pc
  // KILL: request outstanding at pc but its data must be discarded (redirected)
  // HOLD: fetched word parked in hold_instr while the pipeline is frozen
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_KILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pc_inc;

  // 32-bit modulo increment: 0xFFFF_FFFC wraps to 0
  assign pc_inc    = pc_q + 32'd4;

  assign imem_req  = (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    redir_addr_d = redir_addr_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;

    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            // returned word is on the wrong path: drop it and redirect
            pc_d       = branch_addr;
            if_valid_d = 1'b0;
          end else if (freez) begin
            hold_instr_d = imem_rdata;
            state_d      = ST_HOLD;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_inc;
            if_valid_d = 1'b1;
            pc_d       = pc_inc;
          end
        end else begin
          if (branch_taken) begin
            // request must complete at the old address; remember the target
            redir_addr_d = branch_addr;
            if_valid_d   = 1'b0;
            state_d      = ST_KILL;
          end else if (!freez) begin
            if_valid_d = 1'b0;
          end
        end
      end

      ST_KILL: begin
        if_valid_d = 1'b0;
        if (branch_taken) begin
          redir_addr_d = branch_addr;
        end
        if (imem_ack) begin
          pc_d    = branch_taken ? branch_addr : redir_addr_q;
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!freez) begin
          if_instr_d = hold_instr_q;
          if_pc_d    = pc_inc;
          if_valid_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      hold_instr_q <= 32'h0;
      redir_addr_q <= 32'h0;
      if_pc_q      <= 32'h0;
      if_instr_q   <= 32'h0;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      redir_addr_q <= redir_addr_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // a redirect in the same cycle is not a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (freez && !branch_taken && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
